// File: rtl/clksel_pkg.sv
// Shared types and address decode for the CPU clock speed selector.
// Imported by clksel_ctrl and its helpers.
package clksel_pkg;

    typedef enum logic [1:0] {
        ST_FAST    = 2'd0,
        ST_TO_SLOW = 2'd1,
        ST_SLOW    = 2'd2,
        ST_TO_FAST = 2'd3
    } clk_state_t;

    localparam logic [7:0] IO_PAGE_LO_DEF = 8'hFC;
    localparam logic [7:0] IO_PAGE_HI_DEF = 8'hFE;
    localparam logic [7:0] LOW_RAM_END    = 8'h80;

    function automatic logic slow_decode(
        input logic [7:0] bank,
        input logic [7:0] page,
        input logic       shadow_en,
        input logic       force_slow,
        input logic [7:0] io_lo,
        input logic [7:0] io_hi
    );
        logic bank0;
        logic io_hit;
        logic ram_hit;
        bank0   = (bank == 8'h00);
        io_hit  = bank0 && (page >= io_lo) && (page <= io_hi);
        ram_hit = bank0 && (page < LOW_RAM_END) && !shadow_en;
        return force_slow | io_hit | ram_hit;
    endfunction

endpackage

// File: rtl/clksel_ctrl_sync2.sv
// Flop-chain synchroniser for asynchronous clock-switch feedback.
// Depth is STAGES flops; synchronous active-low clear.
module sync2 #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_b,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            chain <= '0;
        end else begin
            chain <= (chain << 1) | STAGES'(d);
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/clksel_ctrl.sv
// CPU speed-selection controller driving the clock switch request,
// stalling the CPU across each switch handshake.
module clksel_ctrl
    import clksel_pkg::*;
#(
    parameter int         SYNC_STAGES    = 2,
    parameter int         DWELL_CYCLES   = 16,
    parameter int         TIMEOUT_CYCLES = 255,
    parameter logic [7:0] IO_PAGE_LO     = IO_PAGE_LO_DEF,
    parameter logic [7:0] IO_PAGE_HI     = IO_PAGE_HI_DEF
) (
    input  logic        hsclk_in,
    input  logic        rst_b,
    input  logic        addr_valid,
    input  logic [7:0]  addr_bank,
    input  logic [7:0]  addr_page,
    input  logic        shadow_en,
    input  logic        force_slow,
    input  logic        hsclk_selected,
    input  logic        lsclk_selected,
    output logic        hsclk_sel,
    output logic        cpu_rdy,
    output logic        switch_err,
    output logic [15:0] switch_count
);

    localparam int DW = $clog2(DWELL_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LD = DW'(DWELL_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES);

    clk_state_t    state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [TW-1:0] timer_inc;
    logic [15:0]   cnt_q, cnt_d;
    logic          sel_q, sel_d;
    logic          rdy_q, rdy_d;
    logic          err_q, err_d;
    logic          hs_sync, ls_sync;
    logic          hs_ack, ls_ack;
    logic          slow_req, timeout;

    sync2 #(.STAGES(SYNC_STAGES)) u_hs_sync (
        .clk   (hsclk_in),
        .rst_b (rst_b),
        .d     (hsclk_selected),
        .q     (hs_sync)
    );

    sync2 #(.STAGES(SYNC_STAGES)) u_ls_sync (
        .clk   (hsclk_in),
        .rst_b (rst_b),
        .d     (lsclk_selected),
        .q     (ls_sync)
    );

    assign slow_req = slow_decode(addr_bank, addr_page, shadow_en,
                                  force_slow, IO_PAGE_LO, IO_PAGE_HI);

    // Both feedbacks high (or low) mid-switch counts as no acknowledge.
    assign hs_ack    = hs_sync & ~ls_sync;
    assign ls_ack    = ls_sync & ~hs_sync;
    assign timer_inc = timer_q + 1'b1;
    assign timeout   = (timer_inc == TMO_LAST);

    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        rdy_d   = rdy_q;
        err_d   = err_q;
        unique case (state_q)
            ST_FAST: begin
                if (force_slow || (addr_valid && slow_req)) begin
                    state_d = ST_TO_SLOW;
                    sel_d   = 1'b0;
                    rdy_d   = 1'b0;
                    timer_d = '0;
                end
            end
            ST_TO_SLOW: begin
                timer_d = timer_inc;
                if (ls_ack) begin
                    state_d = ST_SLOW;
                    rdy_d   = 1'b1;
                    dwell_d = DWELL_LD;
                    cnt_d   = cnt_q + 16'd1;
                end else if (timeout) begin
                    state_d = ST_SLOW;
                    rdy_d   = 1'b1;
                    dwell_d = DWELL_LD;
                    err_d   = 1'b1;
                end
            end
            ST_SLOW: begin
                if (dwell_q != '0) dwell_d = dwell_q - 1'b1;
                // A slow access re-arms the dwell even as it expires.
                if (addr_valid && slow_req) begin
                    dwell_d = DWELL_LD;
                end else if (addr_valid && (dwell_q == '0)) begin
                    state_d = ST_TO_FAST;
                    sel_d   = 1'b1;
                    rdy_d   = 1'b0;
                    timer_d = '0;
                end
            end
            ST_TO_FAST: begin
                timer_d = timer_inc;
                if (hs_ack) begin
                    state_d = ST_FAST;
                    rdy_d   = 1'b1;
                end else if (timeout) begin
                    state_d = ST_SLOW;
                    sel_d   = 1'b0;
                    rdy_d   = 1'b1;
                    dwell_d = DWELL_LD;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_SLOW;
                sel_d   = 1'b0;
                rdy_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge hsclk_in) begin
        if (!rst_b) begin
            state_q <= ST_SLOW;
            dwell_q <= '0;
            timer_q <= '0;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            rdy_q   <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
        end
    end

    assign hsclk_sel    = sel_q;
    assign cpu_rdy      = rdy_q;
    assign switch_err   = err_q;
    assign switch_count = cnt_q;

endmodule

// File: tb/tb_clksel_ctrl.sv
// Bench for clksel_ctrl: directed scenarios plus random accesses,
// checked against a behavioural speed-selection model and a switch plant.
module tb_clksel_ctrl;

    localparam int SYNC  = 2;
    localparam int DWELL = 16;
    localparam int TMO   = 255;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        addr_valid;
    logic [7:0]  addr_bank;
    logic [7:0]  addr_page;
    logic        shadow_en;
    logic        force_slow;
    logic        hs_fb;
    logic        ls_fb;
    logic        hsclk_sel;
    logic        cpu_rdy;
    logic        switch_err;
    logic [15:0] switch_count;

    int total = 0;
    int bad   = 0;

    // Reference model: which clock is requested, whether a switch is
    // in flight, and a delay line standing in for the synchroniser.
    bit       m_fast, m_wait, m_err;
    int       m_dwell, m_waited, m_cnt;
    bit [1:0] hist[$];

    // Clock-switch plant.
    logic sw_target = 1'b0;
    int   sw_pend   = 0;
    int   fix_dly   = 0;
    bit   withhold  = 0;

    always #5 clk = ~clk;

    clksel_ctrl #(
        .SYNC_STAGES    (SYNC),
        .DWELL_CYCLES   (DWELL),
        .TIMEOUT_CYCLES (TMO),
        .IO_PAGE_LO     (8'hFC),
        .IO_PAGE_HI     (8'hFE)
    ) dut (
        .hsclk_in       (clk),
        .rst_b          (rst_b),
        .addr_valid     (addr_valid),
        .addr_bank      (addr_bank),
        .addr_page      (addr_page),
        .shadow_en      (shadow_en),
        .force_slow     (force_slow),
        .hsclk_selected (hs_fb),
        .lsclk_selected (ls_fb),
        .hsclk_sel      (hsclk_sel),
        .cpu_rdy        (cpu_rdy),
        .switch_err     (switch_err),
        .switch_count   (switch_count)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic bit is_slow(int bank, int page, bit shd, bit frc);
        if (frc) return 1;
        if (bank != 0) return 0;
        if (page >= 'hFC && page <= 'hFE) return 1;
        return (page < 'h80) && !shd;
    endfunction

    task automatic model_edge();
        bit [1:0] seen;
        bit ack_h, ack_l, req;
        if (!rst_b) begin
            m_fast = 0; m_wait = 0; m_err = 0;
            m_dwell = 0; m_waited = 0; m_cnt = 0;
            hist.delete();
            repeat (SYNC) hist.push_back(2'b00);
            return;
        end
        seen = hist.pop_front();
        hist.push_back({hs_fb, ls_fb});
        ack_h = seen[1] && !seen[0];
        ack_l = seen[0] && !seen[1];
        req = is_slow(addr_bank, addr_page, shadow_en, force_slow);
        if (!m_wait && m_fast) begin
            if (force_slow || (addr_valid && req)) begin
                m_fast = 0; m_wait = 1; m_waited = 0;
            end
        end else if (!m_wait) begin
            if (addr_valid && req) begin
                m_dwell = DWELL;
            end else if (addr_valid && m_dwell == 0) begin
                m_fast = 1; m_wait = 1; m_waited = 0;
            end else if (m_dwell > 0) begin
                m_dwell--;
            end
        end else if (!m_fast) begin
            if (ack_l) begin
                m_wait = 0; m_dwell = DWELL;
                m_cnt = (m_cnt + 1) % 65536;
            end else if (++m_waited == TMO) begin
                m_wait = 0; m_dwell = DWELL; m_err = 1;
            end
        end else begin
            if (ack_h) begin
                m_wait = 0;
            end else if (++m_waited == TMO) begin
                m_wait = 0; m_fast = 0; m_dwell = DWELL; m_err = 1;
            end
        end
    endtask

    task automatic plant();
        if (hsclk_sel !== sw_target) begin
            sw_target = hsclk_sel;
            hs_fb = 0;
            ls_fb = 0;
            sw_pend = (fix_dly != 0) ? fix_dly : int'($urandom_range(1, 5));
        end else if (sw_pend > 0) begin
            sw_pend--;
            if (sw_pend == 0 && !withhold) begin
                hs_fb = sw_target;
                ls_fb = !sw_target;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("hsclk_sel", hsclk_sel, m_fast);
        chk("cpu_rdy", cpu_rdy, !m_wait);
        chk("switch_err", switch_err, m_err);
        chk("switch_count", switch_count, m_cnt);
        plant();
        addr_valid = 0;
    endtask

    task automatic idle(int n);
        repeat (n) step();
    endtask

    task automatic access(logic [7:0] bank, logic [7:0] page);
        addr_bank  = bank;
        addr_page  = page;
        addr_valid = 1;
        step();
    endtask

    task automatic wait_rdy(int lim);
        int n = 0;
        while (!cpu_rdy && n < lim) begin
            step();
            n++;
        end
        chk("wait_rdy", cpu_rdy, 1);
    endtask

    initial begin
        int n;
        rst_b = 0; addr_valid = 0; addr_bank = 0; addr_page = 0;
        shadow_en = 1; force_slow = 0; hs_fb = 0; ls_fb = 1;
        idle(2);
        chk("rst_sel", hsclk_sel, 0);
        chk("rst_rdy", cpu_rdy, 1);
        chk("rst_err", switch_err, 0);
        chk("rst_cnt", switch_count, 0);
        rst_b = 1;
        step();

        access(8'h00, 8'hFD);
        chk("io_sel", hsclk_sel, 0);
        chk("io_rdy", cpu_rdy, 1);
        chk("io_cnt", switch_count, 0);
        idle(20);

        fix_dly = 3;
        access(8'h01, 8'h20);
        chk("up_sel", hsclk_sel, 1);
        chk("up_rdy", cpu_rdy, 0);
        idle(3);
        n = 0;
        while (!cpu_rdy && n < 20) begin
            step();
            n++;
        end
        chk("ack_lat", n, SYNC + 1);
        chk("fast_sel", hsclk_sel, 1);

        access(8'h00, 8'hFE);
        chk("dn_sel", hsclk_sel, 0);
        chk("dn_rdy", cpu_rdy, 0);
        wait_rdy(40);
        chk("dn_cnt", switch_count, 1);
        idle(4);
        access(8'h01, 8'h20);
        chk("dwell5_sel", hsclk_sel, 0);
        chk("dwell5_rdy", cpu_rdy, 1);
        idle(10);
        access(8'h01, 8'h20);
        chk("dwell16_sel", hsclk_sel, 0);
        access(8'h01, 8'h20);
        chk("dwell17_sel", hsclk_sel, 1);
        chk("dwell17_rdy", cpu_rdy, 0);
        wait_rdy(40);

        shadow_en = 0;
        access(8'h00, 8'h40);
        chk("shd0_sel", hsclk_sel, 0);
        wait_rdy(40);
        idle(20);
        access(8'h02, 8'h00);
        wait_rdy(40);
        chk("shd_fast", hsclk_sel, 1);
        shadow_en = 1;
        access(8'h00, 8'h40);
        chk("shd1_sel", hsclk_sel, 1);
        chk("shd1_rdy", cpu_rdy, 1);
        chk("cnt2", switch_count, 2);

        withhold = 1;
        access(8'h00, 8'hFC);
        n = 0;
        while (!switch_err && n < 300) begin
            step();
            n++;
        end
        chk("tmo_cycles", n, TMO);
        chk("tmo_rdy", cpu_rdy, 1);
        chk("tmo_sel", hsclk_sel, 0);
        chk("tmo_cnt", switch_count, 2);
        withhold = 0;
        ls_fb = 1;
        idle(20);

        access(8'h03, 8'h10);
        chk("tf_rdy", cpu_rdy, 0);
        rst_b = 0;
        step();
        rst_b = 1;
        chk("rtf_sel", hsclk_sel, 0);
        chk("rtf_rdy", cpu_rdy, 1);
        chk("rtf_cnt", switch_count, 0);
        chk("rtf_err", switch_err, 0);
        idle(5);

        fix_dly = 0;
        for (int i = 0; i < 3000; i++) begin
            rst_b = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 23) == 0) force_slow = !force_slow;
            if ($urandom_range(0, 63) == 0) shadow_en = 1'($urandom_range(0, 1));
            addr_valid = ($urandom_range(0, 2) == 0);
            addr_bank = ($urandom_range(0, 1) != 0) ? 8'h00
                      : 8'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                0: addr_page = 8'($urandom_range(8'hFB, 8'hFF));
                1: addr_page = 8'($urandom_range(0, 8'h7F));
                2: addr_page = 8'($urandom_range(8'h7E, 8'h81));
                default: addr_page = 8'($urandom_range(0, 255));
            endcase
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
